// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared encodings for the MEM stage: memory op codes, buffer
//            request width codes, bus widths, FSM state type and op helpers.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  localparam int RAM_ADDR_BUS = 17;
  localparam int REG_BUS      = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic [3:0] MEM_OP_NOP = 4'd0;
  localparam logic [3:0] MEM_OP_LB  = 4'd1;
  localparam logic [3:0] MEM_OP_LH  = 4'd2;
  localparam logic [3:0] MEM_OP_LW  = 4'd3;
  localparam logic [3:0] MEM_OP_LBU = 4'd4;
  localparam logic [3:0] MEM_OP_LHU = 4'd5;
  localparam logic [3:0] MEM_OP_SB  = 4'd6;
  localparam logic [3:0] MEM_OP_SH  = 4'd7;
  localparam logic [3:0] MEM_OP_SW  = 4'd8;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_BYTE = 2'b01;
  localparam logic [1:0] REQ_HALF = 2'b10;
  localparam logic [1:0] REQ_WORD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic [1:0] op_req_code(input logic [3:0] op);
    logic [1:0] code;
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: code = REQ_BYTE;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: code = REQ_HALF;
      MEM_OP_LW, MEM_OP_SW:             code = REQ_WORD;
      default:                          code = REQ_NONE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_load_extend
// Purpose  : Combinational sign/zero extension of load data by load type.
// Ports    : mem_op   in  4     latched memory op
//            mem_data in  XLEN  raw data from the memory buffer
//            ext_data out XLEN  extended writeback word
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl_load_extend
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      mem_op,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] ext_data
);

  always_comb begin
    ext_data = mem_data;
    case (mem_op)
      MEM_OP_LB:  ext_data = {{(XLEN-8){mem_data[7]}}, mem_data[7:0]};
      MEM_OP_LBU: ext_data = {{(XLEN-8){1'b0}}, mem_data[7:0]};
      MEM_OP_LH:  ext_data = {{(XLEN-16){mem_data[15]}}, mem_data[15:0]};
      MEM_OP_LHU: ext_data = {{(XLEN-16){1'b0}}, mem_data[15:0]};
      default:    ext_data = mem_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM pipeline stage. Accepts load/store ops from EX/MEM, drives
//            the byte-serial buffer's width-coded request until its
//            completion pulse, extends load data and registers the MEM/WB
//            writeback bundle. Stalls upstream while an access is in flight.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            valid_i, mem_op_i, addr_i, store_data_i, wd_i, wreg_i, wdata_i
//                                     EX/MEM bundle
//            mem_read_req_o, mem_write_req_o, mem_addr_o, mem_write_data_o
//                                     request side of the memory buffer
//            mem_data_i, mem_data_enable_i
//                                     response side of the memory buffer
//            stall_req_o              hold upstream stages
//            wb_valid_o, wd_o, wreg_o, wdata_o
//                                     registered MEM/WB bundle
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [1:0]        mem_read_req_o,
  output logic [1:0]        mem_write_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_write_data_o,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              mem_data_enable_i,
  output logic              stall_req_o,
  output logic              wb_valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o
);

  state_t          state;
  logic [3:0]      op_q;
  logic [4:0]      wd_q;
  logic            wreg_q;
  logic [XLEN-1:0] load_word;
  logic            accept;

  // Address bits above the RAM width are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[XLEN-1:ADDR_W];

  assign accept = (state == IDLE) && valid_i &&
                  (op_is_load(mem_op_i) || op_is_store(mem_op_i));

  // Released in the completion cycle so upstream advances on the same edge
  // that produces the writeback; forced low while reset is applied.
  assign stall_req_o = !rst &&
                       (accept || ((state == BUSY) && !mem_data_enable_i));

  mem_access_ctrl_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .mem_op  (op_q),
    .mem_data(mem_data_i),
    .ext_data(load_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= MEM_OP_NOP;
      wd_q             <= '0;
      wreg_q           <= 1'b0;
      mem_read_req_o   <= REQ_NONE;
      mem_write_req_o  <= REQ_NONE;
      mem_addr_o       <= '0;
      mem_write_data_o <= '0;
      wb_valid_o       <= 1'b0;
      wd_o             <= '0;
      wreg_o           <= 1'b0;
      wdata_o          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state            <= BUSY;
            op_q             <= mem_op_i;
            wd_q             <= wd_i;
            wreg_q           <= wreg_i;
            mem_addr_o       <= addr_i[ADDR_W-1:0];
            mem_write_data_o <= store_data_i;
            wb_valid_o       <= 1'b0;
            wreg_o           <= 1'b0;
            if (op_is_load(mem_op_i)) begin
              mem_read_req_o <= op_req_code(mem_op_i);
            end else begin
              mem_write_req_o <= op_req_code(mem_op_i);
            end
          end else if (valid_i) begin
            // ALU / NOP ops pass straight through with one cycle latency.
            wb_valid_o <= 1'b1;
            wd_o       <= wd_i;
            wreg_o     <= wreg_i;
            wdata_o    <= wdata_i;
          end else begin
            wb_valid_o <= 1'b0;
            wreg_o     <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_data_enable_i) begin
            // Requests must be gone the cycle after the pulse or the
            // buffer would start the same access again.
            state           <= IDLE;
            mem_read_req_o  <= REQ_NONE;
            mem_write_req_o <= REQ_NONE;
            wb_valid_o      <= 1'b1;
            wd_o            <= wd_q;
            if (op_is_load(op_q)) begin
              wreg_o  <= wreg_q;
              wdata_o <= load_word;
            end else begin
              wreg_o  <= 1'b0;
              wdata_o <= ZERO_WORD[XLEN-1:0];
            end
          end else begin
            wb_valid_o <= 1'b0;
            wreg_o     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl: table of single-cycle
//            pass-through vectors, table of load/store accesses, and
//            hand-written back-to-back and reset-mid-access sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [1:0]  mem_read_req_o;
  logic [1:0]  mem_write_req_o;
  logic [16:0] mem_addr_o;
  logic [31:0] mem_write_data_o;
  logic [31:0] mem_data_i;
  logic        mem_data_enable_i;
  logic        stall_req_o;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;

  int passed = 0;
  int total  = 0;

  mem_access_ctrl #(
    .ADDR_W(17),
    .XLEN  (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .mem_op_i         (mem_op_i),
    .addr_i           (addr_i),
    .store_data_i     (store_data_i),
    .wd_i             (wd_i),
    .wreg_i           (wreg_i),
    .wdata_i          (wdata_i),
    .mem_read_req_o   (mem_read_req_o),
    .mem_write_req_o  (mem_write_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_data_i       (mem_data_i),
    .mem_data_enable_i(mem_data_enable_i),
    .stall_req_o      (stall_req_o),
    .wb_valid_o       (wb_valid_o),
    .wd_o             (wd_o),
    .wreg_o           (wreg_o),
    .wdata_o          (wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic        en;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        exp_wb;
    logic        exp_wreg;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] mdata;
    int          lat;
    logic [1:0]  exp_rreq;
    logic [1:0]  exp_wreq;
    logic [31:0] exp_wdata;
    logic        exp_wreg;
  } mem_vec_t;

  alu_vec_t alu_tab[6];
  mem_vec_t mem_tab[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i           = 1'b0;
    mem_op_i          = 4'd0;
    addr_i            = '0;
    store_data_i      = '0;
    wd_i              = '0;
    wreg_i            = 1'b0;
    wdata_i           = '0;
    mem_data_enable_i = 1'b0;
    mem_data_i        = 32'hFFFF_FFFF;
  endtask

  task automatic run_mem(input mem_vec_t v);
    logic is_store;
    is_store = (v.exp_wreq != 2'b00);
    valid_i      = 1'b1;
    mem_op_i     = v.op;
    addr_i       = v.addr;
    store_data_i = v.sdata;
    wd_i         = v.wd;
    wreg_i       = v.wreg;
    wdata_i      = 32'h5555_AAAA;
    #1;
    chk("accept_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    idle_inputs();
    chk("accept_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("mem_addr", {15'd0, mem_addr_o}, v.addr & 32'h0001_FFFF);
    for (int i = 0; i <= v.lat; i++) begin
      chk("busy_read_req", {30'd0, mem_read_req_o}, {30'd0, v.exp_rreq});
      chk("busy_write_req", {30'd0, mem_write_req_o}, {30'd0, v.exp_wreq});
      if (is_store) chk("write_data_stable", mem_write_data_o, v.sdata);
      if (i < v.lat) begin
        #1;
        chk("busy_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
      end
    end
    mem_data_enable_i = 1'b1;
    mem_data_i        = is_store ? 32'h1234_5678 : v.mdata;
    #1;
    chk("pulse_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    idle_inputs();
    chk("done_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("done_wdata", wdata_o, v.exp_wdata);
    chk("done_wreg", {31'd0, wreg_o}, {31'd0, v.exp_wreg});
    chk("done_wd", {27'd0, wd_o}, {27'd0, v.wd});
    chk("done_read_req", {30'd0, mem_read_req_o}, 32'd0);
    chk("done_write_req", {30'd0, mem_write_req_o}, 32'd0);
    tick();
    chk("after_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("after_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
  endtask

  initial begin
    alu_tab[0] = '{1'b1, 4'd0,  1'b0, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b1};
    alu_tab[1] = '{1'b0, 4'd0,  1'b0, 5'd7,  1'b1, 32'h0000_0777, 1'b0, 1'b0};
    alu_tab[2] = '{1'b1, 4'd12, 1'b0, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    alu_tab[3] = '{1'b1, 4'd15, 1'b0, 5'd1,  1'b1, 32'h0000_0000, 1'b1, 1'b1};
    alu_tab[4] = '{1'b0, 4'd3,  1'b1, 5'd2,  1'b1, 32'h0000_0042, 1'b0, 1'b0};
    alu_tab[5] = '{1'b1, 4'd9,  1'b1, 5'd17, 1'b1, 32'hCAFE_0001, 1'b1, 1'b1};

    mem_tab[0] = '{4'd1, 32'h0000_0010, 32'h0, 5'd3,  1'b1, 32'h0000_0080, 2, 2'b01, 2'b00, 32'hFFFF_FF80, 1'b1};
    mem_tab[1] = '{4'd5, 32'h0000_0022, 32'h0, 5'd4,  1'b1, 32'h0000_F00D, 1, 2'b10, 2'b00, 32'h0000_F00D, 1'b1};
    mem_tab[2] = '{4'd2, 32'h0000_0022, 32'h0, 5'd6,  1'b1, 32'h0000_F00D, 0, 2'b10, 2'b00, 32'hFFFF_F00D, 1'b1};
    mem_tab[3] = '{4'd3, 32'hFFF2_1004, 32'h0, 5'd8,  1'b1, 32'h89AB_CDEF, 1, 2'b11, 2'b00, 32'h89AB_CDEF, 1'b1};
    mem_tab[4] = '{4'd4, 32'h0000_0003, 32'h0, 5'd9,  1'b1, 32'h0000_0080, 0, 2'b01, 2'b00, 32'h0000_0080, 1'b1};
    mem_tab[5] = '{4'd1, 32'h0000_0005, 32'h0, 5'd10, 1'b0, 32'h0000_007F, 1, 2'b01, 2'b00, 32'h0000_007F, 1'b0};
    mem_tab[6] = '{4'd8, 32'h0001_FFFC, 32'hDEAD_BEEF, 5'd11, 1'b1, 32'h0, 3, 2'b00, 2'b11, 32'h0, 1'b0};
    mem_tab[7] = '{4'd7, 32'h0000_0002, 32'h0000_CAFE, 5'd12, 1'b1, 32'h0, 1, 2'b00, 2'b10, 32'h0, 1'b0};
    mem_tab[8] = '{4'd6, 32'h0000_0001, 32'h0000_00A5, 5'd13, 1'b0, 32'h0, 0, 2'b00, 2'b01, 32'h0, 1'b0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_addr", {15'd0, mem_addr_o}, 32'd0);
    chk("rst_wdata_bus", {wd_o, wreg_o, 26'd0} | wdata_o | mem_write_data_o, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      valid_i           = alu_tab[i].valid;
      mem_op_i          = alu_tab[i].op;
      mem_data_enable_i = alu_tab[i].en;
      wd_i              = alu_tab[i].wd;
      wreg_i            = alu_tab[i].wreg;
      wdata_i           = alu_tab[i].wdata;
      addr_i            = 32'h0000_0100;
      #1;
      chk("alu_stall", {31'd0, stall_req_o}, 32'd0);
      tick();
      chk("alu_wb_valid", {31'd0, wb_valid_o}, {31'd0, alu_tab[i].exp_wb});
      chk("alu_wreg", {31'd0, wreg_o}, {31'd0, alu_tab[i].exp_wreg});
      chk("alu_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
      if (alu_tab[i].exp_wb) begin
        chk("alu_wd", {27'd0, wd_o}, {27'd0, alu_tab[i].wd});
        chk("alu_wdata", wdata_o, alu_tab[i].wdata);
      end
    end
    idle_inputs();
    tick();

    for (int i = 0; i < 9; i++) begin
      run_mem(mem_tab[i]);
    end

    // Back-to-back: LW in flight while SB already waits on the inputs.
    valid_i = 1'b1; mem_op_i = 4'd3; addr_i = 32'h0000_0040;
    wd_i = 5'd9; wreg_i = 1'b1;
    #1;
    chk("b2b_lw_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    mem_op_i = 4'd6; addr_i = 32'h0000_0041; store_data_i = 32'h0000_005A;
    wd_i = 5'd14; wreg_i = 1'b0;
    chk("b2b_lw_read_req", {30'd0, mem_read_req_o}, 32'd3);
    chk("b2b_lw_write_req", {30'd0, mem_write_req_o}, 32'd0);
    tick();
    chk("b2b_busy_ignores_sb", {30'd0, mem_write_req_o}, 32'd0);
    mem_data_enable_i = 1'b1; mem_data_i = 32'h1122_3344;
    #1;
    chk("b2b_pulse_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    mem_data_enable_i = 1'b0;
    chk("b2b_lw_wdata", wdata_o, 32'h1122_3344);
    chk("b2b_lw_wd", {27'd0, wd_o}, 32'd9);
    chk("b2b_gap_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
    chk("b2b_sb_accept_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    valid_i = 1'b0; mem_op_i = 4'd0;
    chk("b2b_sb_write_req", {30'd0, mem_write_req_o}, 32'd1);
    chk("b2b_sb_read_req", {30'd0, mem_read_req_o}, 32'd0);
    chk("b2b_sb_addr", {15'd0, mem_addr_o}, 32'h0000_0041);
    chk("b2b_sb_data", mem_write_data_o, 32'h0000_005A);
    mem_data_enable_i = 1'b1;
    tick();
    mem_data_enable_i = 1'b0;
    chk("b2b_sb_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("b2b_sb_wreg", {31'd0, wreg_o}, 32'd0);
    tick();
    chk("b2b_no_dup_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
    chk("b2b_no_dup_wb", {31'd0, wb_valid_o}, 32'd0);

    // Reset while a word load is pending, then a stray completion pulse.
    idle_inputs();
    valid_i = 1'b1; mem_op_i = 4'd3; addr_i = 32'h0000_0080;
    wd_i = 5'd20; wreg_i = 1'b1;
    tick();
    idle_inputs();
    chk("rstmid_read_req", {30'd0, mem_read_req_o}, 32'd3);
    rst = 1'b1;
    tick();
    chk("rstmid_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
    chk("rstmid_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rstmid_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    rst = 1'b0;
    mem_data_enable_i = 1'b1; mem_data_i = 32'h0BAD_0BAD;
    #1;
    chk("late_pulse_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    mem_data_enable_i = 1'b0;
    chk("late_pulse_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("late_pulse_reqs", {28'd0, mem_read_req_o, mem_write_req_o}, 32'd0);
    chk("late_pulse_stall_after", {31'd0, stall_req_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM pipeline stage of the RISC-V core; sits between the EX/MEM latch and the byte-serial memory buffer.
- Decodes load/store ops and drives the buffer's width-coded read/write request until completion.
- Sign/zero-extends load data and presents a registered writeback bundle to MEM/WB.
- Stalls the upstream pipeline for the whole duration of the memory access.

Parameters:
- ADDR_W, 17, RAM byte-address width driven to the memory buffer.
- XLEN, 32, register/data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  1  EX/MEM bundle valid this cycle
- mem_op_i  in  4  0 NOP/ALU, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP
- addr_i  in  XLEN  effective address (ALU result)
- store_data_i  in  XLEN  rs2 value for stores
- wd_i  in  5  destination register index
- wreg_i  in  1  destination write enable
- wdata_i  in  XLEN  ALU result for non-memory ops
- mem_read_req_o  out  2  00 none, 01 byte, 10 half, 11 word
- mem_write_req_o  out  2  same encoding
- mem_addr_o  out  ADDR_W  addr_i[ADDR_W-1:0], latched
- mem_write_data_o  out  XLEN  latched store data
- mem_data_i  in  XLEN  load data from buffer, zero-extended by buffer
- mem_data_enable_i  in  1  one-cycle completion pulse from buffer
- stall_req_o  out  1  hold upstream stages
- wb_valid_o  out  1  writeback bundle valid
- wd_o  out  5  writeback register index
- wreg_o  out  1  writeback enable
- wdata_o  out  XLEN  writeback data

Behaviour:
- Reset: rst synchronous, active-high. All outputs 0; state IDLE; latched addr/data/op cleared.
- States: IDLE, BUSY.
- IDLE, valid_i=1, op NOP/ALU: next edge wb_valid_o=1, wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i; 1-cycle latency; stall_req_o=0.
- IDLE, valid_i=0: wb_valid_o=0 and wreg_o=0 next edge.
- IDLE, valid_i=1, op load/store:
  - stall_req_o=1 combinationally in that cycle.
  - Latch op, addr, store data, wd, wreg.
  - Go to BUSY. wb_valid_o=0 next edge.
  - Next edge sets the req code: LB/LBU/SB 01, LH/LHU/SH 10, LW/SW 11.
  - Loads drive only mem_read_req_o; stores drive only mem_write_req_o; the other request stays 00.
- BUSY, mem_data_enable_i=0: hold request, address and data stable; stall_req_o=1; wb_valid_o=0.
- BUSY, mem_data_enable_i=1:
  - stall_req_o=0 in the same cycle, so upstream advances on this edge.
  - On the edge: requests drop to 00, state to IDLE, wb_valid_o=1.
  - Requests must be 00 in the following cycle, otherwise the buffer re-issues the access.
- Load result: LB = sign-extend mem_data_i[7:0]; LBU = zero-extend [7:0]; LH = sign-extend [15:0]; LHU = zero-extend [15:0]; LW = [31:0]. Loads: wreg_o=latched wreg, wd_o=latched wd.
- Store completion: wreg_o=0, wdata_o=0, wd_o=latched wd.
- No alignment checks: the buffer is byte-serial and any address is legal. Upper address bits above ADDR_W are discarded.
- valid_i/mem_op_i changes while BUSY are ignored; upstream is stalled.
- mem_data_enable_i while IDLE is ignored.
- Completion cycle with a new valid memory op on inputs: not accepted that cycle, because upstream only updates on that edge. The new op is accepted next cycle from IDLE.
- Reset mid-access: immediate IDLE with requests 00, no writeback, stall_req_o=0.
- Minimum load latency: accept cycle, then the buffer's cycles, then the writeback edge. stall_req_o is high from the accept cycle up to the pulse cycle exclusive.

Decomposition:
- Shared package/defines: MEM_OP_* encodings, REQ_NONE/BYTE/HALF/WORD codes, RamAddrBus/RegBus widths, ZeroWord.
- Sub-module load_extend (combinational): mem_op + mem_data -> extended word.

Test Plan:
- ALU pass-through: valid, op 0, wd=5, wreg=1, wdata=0x1234 -> next cycle wb_valid=1, wd_o=5, wdata_o=0x1234, stall never high.
- LB sign: op LB, addr 0x00010, buffer returns 0x00000080 after 3 cycles -> read_req=01, mem_addr_o=0x10, stall high until pulse, wdata_o=0xFFFFFF80, read_req 00 after pulse.
- LHU/LH: buffer returns 0x0000F00D -> LHU gives 0x0000F00D, LH gives 0xFFFFF00D; req code 10.
- SW: store_data 0xDEADBEEF, addr 0x1FFFC -> write_req=11, write_data held stable until pulse, then wreg_o=0, write_req 00 the next cycle.
- Back-to-back: LW then SB on inputs -> SB accepted exactly one cycle after LW completion, no dropped or duplicated request.
- Reset while BUSY with LW pending -> requests 00, stall 0, no wb_valid; a late mem_data_enable pulse is ignored.
